// File: rtl/vga_pattern_gen.sv
// VGA timing generator with selectable test patterns, grayscale conversion and
// frame-synchronous horizontal scrolling. Every output is registered one cycle after the counters.
module vga_pattern_gen #(
  parameter int CD         = 12,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int BAR_W      = 80,
  parameter int CHK_LOG2   = 5,
  parameter int GRAD_SHIFT = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    mode,
  input  logic [CD-1:0] back_rgb,
  input  logic          gray_en,
  input  logic          scroll_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CD-1:0] rgb,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int CW    = CD / 3;
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW   = $clog2(H_TOT);
  localparam int VCW   = $clog2(V_TOT);
  localparam int SOW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int XW0   = HCW + 1;
  localparam int XW1   = (GRAD_SHIFT + CW > XW0) ? GRAD_SHIFT + CW : XW0;
  localparam int XW    = (CHK_LOG2 + 1 > XW1) ? CHK_LOG2 + 1 : XW1;
  localparam int YW    = (CHK_LOG2 + 1 > VCW) ? CHK_LOG2 + 1 : VCW;
  localparam logic SP  = (SYNC_POL != 0);

  logic [HCW-1:0] hCount_q, hCount_d;
  logic [VCW-1:0] vCount_q, vCount_d;
  logic [2:0]     mode_q, mode_d;
  logic           gray_q, gray_d;
  logic           scroll_q, scroll_d;
  logic [SOW-1:0] scrollOff_q, scrollOff_d;
  logic [15:0]    frameCnt_q, frameCnt_d;

  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           videoOn_q, videoOn_d;
  logic [CD-1:0]  rgb_q, rgb_d;
  logic           frameStart_q, frameStart_d;

  logic           hLast, vLast, frameEnd;
  logic [XW-1:0]  xSum, xEff;
  logic [YW-1:0]  yPos;
  logic [2:0]     barIdx;
  logic [CD-1:0]  pattern, pixel;
  logic [CW-1:0]  chR, chG, chB, grayVal;
  logic [CW+3:0]  rExt, gExt, bExt, graySum;

  // Raster counters plus the per-frame latches, all of which move on the frame boundary
  always_comb begin
    hLast       = (hCount_q == HCW'(H_TOT - 1));
    vLast       = (vCount_q == VCW'(V_TOT - 1));
    frameEnd    = hLast && vLast;
    hCount_d    = hLast ? '0 : hCount_q + HCW'(1);
    vCount_d    = vCount_q;
    mode_d      = mode_q;
    gray_d      = gray_q;
    scroll_d    = scroll_q;
    scrollOff_d = scrollOff_q;
    frameCnt_d  = frameCnt_q;
    if (hLast) begin
      vCount_d = vLast ? '0 : vCount_q + VCW'(1);
    end
    if (frameEnd) begin
      mode_d     = mode;
      gray_d     = gray_en;
      scroll_d   = scroll_en;
      frameCnt_d = frameCnt_q + 16'd1;
      // The increment uses the scroll bit latched one frame earlier
      if (scroll_q) begin
        scrollOff_d = (scrollOff_q == SOW'(H_ACTIVE - 1)) ? '0 : scrollOff_q + SOW'(1);
      end
    end
  end

  // Pixel pipeline input: sync, active flag and colour derived from the current counters
  always_comb begin
    hsync_d      = ((hCount_q >= HCW'(H_ACTIVE + H_FP)) &&
                    (hCount_q <= HCW'(H_ACTIVE + H_FP + H_SYNC - 1))) ? SP : ~SP;
    vsync_d      = ((vCount_q >= VCW'(V_ACTIVE + V_FP)) &&
                    (vCount_q <= VCW'(V_ACTIVE + V_FP + V_SYNC - 1))) ? SP : ~SP;
    videoOn_d    = (hCount_q < HCW'(H_ACTIVE)) && (vCount_q < VCW'(V_ACTIVE));
    frameStart_d = (hCount_q == '0) && (vCount_q == '0);

    xSum = XW'(hCount_q) + XW'(scrollOff_q);
    xEff = (xSum >= XW'(H_ACTIVE)) ? xSum - XW'(H_ACTIVE) : xSum;
    yPos = YW'(vCount_q);

    barIdx = '0;
    for (int k = 1; k < 8; k++) begin
      if (XW'(k * BAR_W) <= xEff) begin
        barIdx = barIdx + 3'd1;
      end
    end

    case (mode_q)
      3'd0: pattern = back_rgb;
      3'd1: pattern = {{CW{barIdx[2]}}, {CW{barIdx[1]}}, {CW{barIdx[0]}}};
      3'd2: pattern = (xEff[CHK_LOG2] ^ yPos[CHK_LOG2]) ? '1 : '0;
      3'd3: pattern = {3{xEff[GRAD_SHIFT +: CW]}};
      3'd4: pattern = ((xEff == '0) || (xEff == XW'(H_ACTIVE - 1)) ||
                       (yPos == '0) || (yPos == YW'(V_ACTIVE - 1))) ? '1 : back_rgb;
      default: pattern = '0;
    endcase

    // Luma weights 5/9/2 sum to 16, so the shifted result always fits in one channel
    chR     = pattern[CD-1 -: CW];
    chG     = pattern[2*CW-1 -: CW];
    chB     = pattern[CW-1:0];
    rExt    = {4'b0000, chR};
    gExt    = {4'b0000, chG};
    bExt    = {4'b0000, chB};
    graySum = (rExt << 2) + rExt + (gExt << 3) + gExt + (bExt << 1);
    grayVal = CW'(graySum >> 4);

    pixel = gray_q ? {3{grayVal}} : pattern;
    rgb_d = videoOn_d ? pixel : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hCount_q     <= '0;
      vCount_q     <= '0;
      mode_q       <= '0;
      gray_q       <= 1'b0;
      scroll_q     <= 1'b0;
      scrollOff_q  <= '0;
      frameCnt_q   <= '0;
      hsync_q      <= ~SP;
      vsync_q      <= ~SP;
      videoOn_q    <= 1'b0;
      rgb_q        <= '0;
      frameStart_q <= 1'b0;
    end else begin
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      mode_q       <= mode_d;
      gray_q       <= gray_d;
      scroll_q     <= scroll_d;
      scrollOff_q  <= scrollOff_d;
      frameCnt_q   <= frameCnt_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      videoOn_q    <= videoOn_d;
      rgb_q        <= rgb_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = videoOn_q;
  assign rgb         = rgb_q;
  assign frame_start = frameStart_q;
  assign frame_cnt   = frameCnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen using a reduced raster (40x20 total, 32x16 visible)
// and a queue of expected pixels checked as the raster reaches them.
module tb_vga_pattern_gen;

  localparam int CD    = 12;
  localparam int HA    = 32;
  localparam int HFP   = 2;
  localparam int HS    = 4;
  localparam int HBP   = 2;
  localparam int VA    = 16;
  localparam int VFP   = 1;
  localparam int VS    = 2;
  localparam int VBP   = 1;
  localparam int HT    = HA + HFP + HS + HBP;
  localparam int VT    = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    mode;
  logic [CD-1:0] backRgb;
  logic          grayEn;
  logic          scrollEn;
  logic          hsync, vsync, videoOn, frameStart;
  logic [CD-1:0] rgb;
  logic [15:0]   frameCnt;

  typedef struct {
    string         tag;
    bit            newFrame;
    int            x;
    int            y;
    logic [CD-1:0] expRgb;
  } item_t;

  item_t scoreQ[$];
  int    checks   = 0;
  int    failures = 0;
  int    pos      = 0;
  int    cyc;

  vga_pattern_gen #(
    .CD(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(0), .BAR_W(4), .CHK_LOG2(2), .GRAD_SHIFT(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .back_rgb(backRgb),
    .gray_en(grayEn),
    .scroll_en(scrollEn),
    .hsync(hsync),
    .vsync(vsync),
    .video_on(videoOn),
    .rgb(rgb),
    .frame_start(frameStart),
    .frame_cnt(frameCnt)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [CD-1:0] expected);
    checkVal(tag, 32'(rgb), 32'(expected));
  endtask

  task automatic applyStimulus(input logic [2:0] m, input logic [CD-1:0] b, input logic g, input logic s);
    mode     = m;
    backRgb  = b;
    grayEn   = g;
    scrollEn = s;
  endtask

  task automatic pushItem(input string tag, input bit nf, input int x, input int y, input logic [CD-1:0] e);
    item_t it;
    it.tag      = tag;
    it.newFrame = nf;
    it.x        = x;
    it.y        = y;
    it.expRgb   = e;
    scoreQ.push_back(it);
  endtask

  // Advance to the next frame_start sample; pos counts cycles since it
  task automatic waitNextFrame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frameStart !== 1'b1 && n < 2 * FRAME);
    checkVal("frame_start_seen", 32'(frameStart), 32'd1);
    pos = 0;
  endtask

  task automatic waitFor(input int sel, input logic val, output int cycles);
    int   n = 0;
    logic s;
    do begin
      @(negedge clk);
      pos++;
      n++;
      case (sel)
        0:       s = hsync;
        1:       s = vsync;
        2:       s = videoOn;
        default: s = frameStart;
      endcase
    end while (s !== val && n < 2 * FRAME);
    cycles = (s === val) ? n : -1;
  endtask

  task automatic gotoPixel(input int x, input int y);
    int target = y * HT + x;
    while (pos < target) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic drainQueue();
    item_t it;
    while (scoreQ.size() > 0) begin
      it = scoreQ.pop_front();
      if (it.newFrame) waitNextFrame();
      gotoPixel(it.x, it.y);
      checkOutput(it.tag, it.expRgb);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(3'd0, 12'h123, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkVal("rst_hsync", 32'(hsync), 32'd1);
    checkVal("rst_vsync", 32'(vsync), 32'd1);
    checkVal("rst_video_on", 32'(videoOn), 32'd0);
    checkVal("rst_rgb", 32'(rgb), 32'd0);
    checkVal("rst_frame_start", 32'(frameStart), 32'd0);
    checkVal("rst_frame_cnt", 32'(frameCnt), 32'd0);

    reset = 1'b0;
    waitNextFrame();
    checkVal("first_frame_cnt", 32'(frameCnt), 32'd0);
    checkVal("first_video_on", 32'(videoOn), 32'd1);
    checkOutput("first_pixel", 12'h123);

    waitFor(0, 1'b0, cyc);
    checkVal("hsync_start", pos, HA + HFP);
    waitFor(0, 1'b1, cyc);
    checkVal("hsync_end", pos, HA + HFP + HS);
    waitFor(2, 1'b1, cyc);
    checkVal("line_period", pos, HT);
    waitFor(1, 1'b0, cyc);
    checkVal("vsync_start", pos, (VA + VFP) * HT);
    waitFor(1, 1'b1, cyc);
    checkVal("vsync_end", pos, (VA + VFP + VS) * HT);
    waitFor(3, 1'b1, cyc);
    checkVal("frame_period", pos, FRAME);
    checkVal("frame_cnt_1", 32'(frameCnt), 32'd1);
    waitNextFrame();
    checkVal("frame_cnt_2", 32'(frameCnt), 32'd2);

    applyStimulus(3'd1, 12'h123, 1'b0, 1'b0);
    pushItem("bar0_x0", 1'b1, 0, 0, 12'h000);
    pushItem("bar0_x3", 1'b0, 3, 0, 12'h000);
    pushItem("bar1_x4", 1'b0, 4, 0, 12'h00F);
    pushItem("bar1_x7", 1'b0, 7, 1, 12'h00F);
    pushItem("bar4_x16", 1'b0, 16, 2, 12'hF00);
    pushItem("bar4_x19", 1'b0, 19, 2, 12'hF00);
    pushItem("bar7_x28", 1'b0, 28, 3, 12'hFFF);
    pushItem("bar7_x31", 1'b0, 31, 3, 12'hFFF);
    pushItem("blank_rgb", 1'b0, 35, 3, 12'h000);
    pushItem("bar2_x10", 1'b0, 10, 5, 12'h0F0);
    drainQueue();

    applyStimulus(3'd0, 12'hF00, 1'b1, 1'b0);
    pushItem("gray_red", 1'b1, 5, 0, 12'h444);
    drainQueue();
    applyStimulus(3'd0, 12'hFFF, 1'b1, 1'b0);
    pushItem("gray_white", 1'b1, 5, 0, 12'hFFF);
    drainQueue();
    applyStimulus(3'd0, 12'h0F0, 1'b1, 1'b0);
    pushItem("gray_green", 1'b1, 5, 0, 12'h888);
    drainQueue();

    applyStimulus(3'd0, 12'h0AB, 1'b0, 1'b0);
    pushItem("back_plain", 1'b1, 5, 0, 12'h0AB);
    drainQueue();
    gotoPixel(0, 8);
    applyStimulus(3'd2, 12'h0AB, 1'b0, 1'b0);
    pushItem("mode_hold", 1'b0, 5, 10, 12'h0AB);
    pushItem("chk_origin", 1'b1, 0, 0, 12'h000);
    pushItem("chk_white", 1'b0, 4, 0, 12'hFFF);
    pushItem("chk_black", 1'b0, 4, 4, 12'h000);
    drainQueue();

    applyStimulus(3'd1, 12'h0AB, 1'b0, 1'b1);
    pushItem("scroll_pre", 1'b1, 3, 0, 12'h000);
    drainQueue();
    applyStimulus(3'd1, 12'h0AB, 1'b0, 1'b0);
    pushItem("scroll_one", 1'b1, 3, 0, 12'h00F);
    pushItem("scroll_wrapx", 1'b0, 31, 0, 12'h000);
    pushItem("scroll_hold", 1'b1, 3, 0, 12'h00F);
    drainQueue();

    applyStimulus(3'd1, 12'h0AB, 1'b0, 1'b1);
    repeat (30) waitNextFrame();
    applyStimulus(3'd1, 12'h0AB, 1'b0, 1'b0);
    pushItem("wrap_x0", 1'b1, 0, 0, 12'hFFF);
    pushItem("wrap_x1", 1'b0, 1, 0, 12'h000);
    pushItem("wrap_x5", 1'b0, 5, 0, 12'h00F);
    drainQueue();

    gotoPixel(10, 8);
    reset = 1'b1;
    #1;
    checkVal("midrst_hsync", 32'(hsync), 32'd1);
    checkVal("midrst_vsync", 32'(vsync), 32'd1);
    checkVal("midrst_video_on", 32'(videoOn), 32'd0);
    checkVal("midrst_rgb", 32'(rgb), 32'd0);
    checkVal("midrst_frame_start", 32'(frameStart), 32'd0);
    checkVal("midrst_frame_cnt", 32'(frameCnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkVal("post_rst_frame_start", 32'(frameStart), 32'd1);
    checkVal("post_rst_frame_cnt", 32'(frameCnt), 32'd0);
    checkOutput("post_rst_mode0", 12'h0AB);
    @(negedge clk);
    checkVal("post_rst_fs_single", 32'(frameStart), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
